// File: rtl/bilinear_pkg.sv
// Shared types and widths for the bilinear scaler scheduling logic.
package bilinear_pkg;

   localparam int unsigned FRAC_W  = 16;
   localparam int unsigned COORD_W = 16;
   localparam int unsigned ACC_W   = FRAC_W + COORD_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ROW,
      S_LINE,
      S_HBLANK,
      S_FRAME_END
   } sched_state_t;

   // Source rows that must be buffered before a destination line on row y_int
   // can be interpolated; the bottom row duplicates itself, so cap at height.
   function automatic logic [COORD_W:0] rows_needed(
      input logic [COORD_W-1:0] y_int,
      input logic [COORD_W-1:0] height
   );
      logic [COORD_W:0] n;
      n = {1'b0, y_int} + (COORD_W+1)'(2);
      return (n > {1'b0, height}) ? {1'b0, height} : n;
   endfunction

endpackage

// File: rtl/bilinear_coord_step.sv
// Q16 coordinate accumulator with a wrapping step counter; one instance walks
// pixels along a line, another walks destination lines down the frame.
module bilinear_coord_step
   import bilinear_pkg::*;
#(
   parameter int unsigned C_COUNT = 1024,
   parameter int unsigned C_RATIO = 40960
) (
   input  logic             clk_in2,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             step,
   output logic [ACC_W-1:0] acc,
   output logic             last
);

   localparam logic [ACC_W-1:0]   RATIO    = ACC_W'(C_RATIO);
   localparam logic [COORD_W-1:0] CNT_LAST = COORD_W'(C_COUNT - 1);

   logic [COORD_W-1:0] count;

   assign last = (count == CNT_LAST);

   always_ff @(posedge clk_in2 or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         count <= '0;
      end else if (clear) begin
         acc   <= '0;
         count <= '0;
      end else if (step) begin
         acc   <= acc + RATIO;
         count <= last ? '0 : count + COORD_W'(1);
      end
   end

endmodule

// File: rtl/bilinear_scale_scheduler.sv
// Destination-domain sequencer for the bilinear scaler: walks Q16 source
// coordinates, gates each line on buffered source rows, times dst frames.
module bilinear_scale_scheduler
   import bilinear_pkg::*;
#(
   parameter int unsigned C_SRC_IMG_WIDTH  = 640,
   parameter int unsigned C_SRC_IMG_HEIGHT = 480,
   parameter int unsigned C_DST_IMG_WIDTH  = 1024,
   parameter int unsigned C_DST_IMG_HEIGHT = 768,
   parameter int unsigned C_X_RATIO        = 40960,
   parameter int unsigned C_Y_RATIO        = 40960,
   parameter int unsigned C_HBLANK         = 16
) (
   input  logic               clk_in2,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               src_row_done,
   input  logic               dp_ready,
   output logic               pix_valid,
   output logic [COORD_W-1:0] x_int,
   output logic [FRAC_W-1:0]  x_frac,
   output logic [COORD_W-1:0] y_int,
   output logic [FRAC_W-1:0]  y_frac,
   output logic               x_last,
   output logic               y_last,
   output logic               dst_vsync,
   output logic               dst_href,
   output logic               src_row_release,
   output logic               frame_done,
   output logic               frame_overrun
);

   localparam logic [COORD_W-1:0] SRC_W_LAST  = COORD_W'(C_SRC_IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] SRC_H       = COORD_W'(C_SRC_IMG_HEIGHT);
   localparam logic [COORD_W-1:0] SRC_H_LAST  = COORD_W'(C_SRC_IMG_HEIGHT - 1);
   localparam logic [COORD_W-1:0] HB_LAST     = COORD_W'(C_HBLANK - 1);
   localparam bit                 Y_ALWAYS_STEP = (C_Y_RATIO >= (1 << FRAC_W));
   localparam logic [FRAC_W:0]    Y_CARRY_THR =
      (FRAC_W+1)'((1 << FRAC_W) - (C_Y_RATIO % (1 << FRAC_W)));

   sched_state_t       state, state_nxt;
   logic [COORD_W-1:0] hb_cnt;
   logic [COORD_W-1:0] rows_wr;
   logic [ACC_W-1:0]   x_acc, y_acc;
   logic               x_cnt_last, y_cnt_last;
   logic               final_line_q;
   logic               start_frame, hb_first, hb_end, line_done;
   logic               rows_ok, final_now, y_carry;

   assign start_frame = frame_start && (state == S_IDLE);
   assign hb_first    = (state == S_HBLANK) && (hb_cnt == '0);
   assign hb_end      = (hb_cnt == HB_LAST);
   assign line_done   = (state == S_LINE) && dp_ready && x_cnt_last;
   assign rows_ok     = ({1'b0, rows_wr} >= rows_needed(y_int, SRC_H));
   assign final_now   = hb_first ? y_cnt_last : final_line_q;

   // The integer part of y moves on this step exactly when the current
   // fraction plus the ratio's fraction carries, so no second adder is needed.
   assign y_carry = Y_ALWAYS_STEP || ({1'b0, y_frac} >= Y_CARRY_THR);

   bilinear_coord_step #(
      .C_COUNT (C_DST_IMG_WIDTH),
      .C_RATIO (C_X_RATIO)
   ) u_x_step (
      .clk_in2 (clk_in2),
      .rst_n   (rst_n),
      .clear   (start_frame || hb_first),
      .step    ((state == S_LINE) && dp_ready),
      .acc     (x_acc),
      .last    (x_cnt_last)
   );

   bilinear_coord_step #(
      .C_COUNT (C_DST_IMG_HEIGHT),
      .C_RATIO (C_Y_RATIO)
   ) u_y_step (
      .clk_in2 (clk_in2),
      .rst_n   (rst_n),
      .clear   (start_frame),
      .step    (hb_first),
      .acc     (y_acc),
      .last    (y_cnt_last)
   );

   always_ff @(posedge clk_in2 or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (frame_start) state_nxt = S_WAIT_ROW;
         S_WAIT_ROW:  if (rows_ok)     state_nxt = S_LINE;
         S_LINE:      if (line_done)   state_nxt = S_HBLANK;
         S_HBLANK:    if (hb_end)      state_nxt = final_now ? S_FRAME_END : S_WAIT_ROW;
         S_FRAME_END: if (hb_end)      state_nxt = S_IDLE;
         default:                      state_nxt = S_IDLE;
      endcase
   end

   // The line counter lives in u_y_step and advances on the first blanking
   // cycle, so the last-line decision is latched there for the blanking end.
   always_ff @(posedge clk_in2 or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt       <= '0;
         final_line_q <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            hb_cnt <= '0;
         end else if ((state == S_HBLANK) || (state == S_FRAME_END)) begin
            hb_cnt <= hb_cnt + COORD_W'(1);
         end
         if (hb_first) begin
            final_line_q <= y_cnt_last;
         end
         frame_done <= (state == S_FRAME_END) && hb_end;
      end
   end

   always_ff @(posedge clk_in2 or negedge rst_n) begin
      if (!rst_n) begin
         rows_wr <= '0;
      end else if (state == S_IDLE) begin
         if (frame_start) begin
            rows_wr <= src_row_done ? COORD_W'(1) : '0;
         end
      end else if (src_row_done && (rows_wr < SRC_H)) begin
         rows_wr <= rows_wr + COORD_W'(1);
      end
   end

   assign pix_valid       = (state == S_LINE);
   assign dst_href        = pix_valid;
   assign dst_vsync       = (state != S_IDLE);
   assign frame_overrun   = frame_start && (state != S_IDLE);
   assign src_row_release = hb_first && !y_cnt_last && y_carry;

   assign x_int  = x_acc[ACC_W-1:FRAC_W];
   assign x_frac = x_acc[FRAC_W-1:0];
   assign y_int  = y_acc[ACC_W-1:FRAC_W];
   assign y_frac = y_acc[FRAC_W-1:0];
   assign x_last = (x_int == SRC_W_LAST);
   assign y_last = (y_int == SRC_H_LAST);

endmodule

// File: doc/bilinear_scale_scheduler.md
# bilinear_scale_scheduler

Single-clock sequencer for the bilinear interpolation datapath, in the output (`clk_in2`) domain. It walks destination coordinates by accumulating the Q16 scale ratios. For each destination line it waits until both required source rows sit in the line buffer, then issues one coordinate per accepted cycle. It also generates destination frame and line timing, and tells the line-buffer writer when a source row may be overwritten.

## Interface
- `C_SRC_IMG_WIDTH`, 640: source pixels per line.
- `C_SRC_IMG_HEIGHT`, 480: source lines per frame.
- `C_DST_IMG_WIDTH`, 1024: destination pixels per line.
- `C_DST_IMG_HEIGHT`, 768: destination lines per frame.
- `C_X_RATIO`, 40960: floor(src_w/dst_w·2^16); legal range 1..65536 (upscale or unity only).
- `C_Y_RATIO`, 40960: floor(src_h/dst_h·2^16); legal range 1..65536.
- `C_HBLANK`, 16: idle cycles after each destination line and before vsync falls.
- `clk_in2` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `frame_start` in 1: one-cycle pulse on a source vsync rise, already synchronised to `clk_in2`.
- `src_row_done` in 1: one-cycle pulse for each complete source row written to the line buffer.
- `dp_ready` in 1: the datapath accepts the current coordinate.
- `pix_valid` out 1: a coordinate is presented.
- `x_int` out 16, `x_frac` out 16: integer and fractional parts of the source x coordinate.
- `y_int` out 16, `y_frac` out 16: integer and fractional parts of the source y coordinate.
- `x_last` out 1: `x_int` == W−1; the datapath duplicates the right neighbour.
- `y_last` out 1: `y_int` == H−1; the datapath duplicates the lower neighbour.
- `dst_vsync` out 1: destination frame active.
- `dst_href` out 1: destination line active, equal to `pix_valid`.
- `src_row_release` out 1: pulse; the oldest held source row may be overwritten.
- `frame_done` out 1: pulse on the cycle `dst_vsync` falls.
- `frame_overrun` out 1: pulse when `frame_start` arrives outside IDLE.

## Operation
- **States:** IDLE, WAIT_ROW, LINE, HBLANK, FRAME_END.
- **IDLE:**
  - On `frame_start`: clear `rows_wr`, `x_acc`, `y_acc` and the line counter, set `dst_vsync`, go to WAIT_ROW.
- **WAIT_ROW:**
  - Move to LINE when `rows_wr` ≥ min(`y_int`+2, H).
- **LINE:**
  - `pix_valid`=1 with the coordinate from `x_acc`: `x_int`=`x_acc`[31:16], `x_frac`=`x_acc`[15:0].
  - On `pix_valid`&`dp_ready`: `x_acc` += `C_X_RATIO` and the pixel counter increments.
  - After pixel W_dst−1 is accepted, go to HBLANK.
- **HBLANK:**
  - Runs `C_HBLANK` cycles.
  - On the first cycle: `x_acc`=0 and `y_acc` += `C_Y_RATIO`. If the new `y_int` exceeds the old one, pulse `src_row_release`.
  - At the end: go to FRAME_END if the line counter equals H_dst−1, otherwise increment it and go to WAIT_ROW.
- **FRAME_END:**
  - Hold `dst_vsync` for `C_HBLANK` cycles, then clear it, pulse `frame_done`, go to IDLE.
- **Row counting:**
  - `rows_wr` increments on `src_row_done` in every non-IDLE state and saturates at H.
  - In IDLE, a `src_row_done` in the same cycle as `frame_start` counts as row 1. A `src_row_done` without `frame_start` in IDLE is ignored.
- **`frame_start` outside IDLE:**
  - Dropped. Pulse `frame_overrun`; the current frame continues unchanged.
- **Arithmetic:**
  - `x_acc` and `y_acc` are 32-bit unsigned.
  - Maximum value is (dst−1)·ratio < 2^26, so no overflow.
  - No multipliers.
- **Flags:**
  - `x_last` and `y_last` are compare results on the registered integer parts.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. The effect is immediate, including mid-line.
- **Frame start:** `dst_vsync` rises 1 cycle after `frame_start`.
- **Row gate:** `pix_valid` rises 1 cycle after the WAIT_ROW condition becomes true.
- **Handshake:** when `pix_valid`=1 and `dp_ready`=0, all coordinate outputs hold stable. A pixel is never dropped and never repeated.
- **Line length:** exactly W_dst accepted pixels; `dst_href` has no gaps while `dp_ready`=1.
- **Pulse widths:** `src_row_release`, `frame_done` and `frame_overrun` are each exactly 1 cycle.
- **Release count:** H−1 release pulses per frame, given unity-or-upscale ratios.

## Structure
- Shared package `bilinear_pkg`:
  - state enum `sched_state_t`
  - the Q16 fraction width constant (16)
  - the coordinate width constant (16)
- The handshake pixel counter and `x_acc` form a natural sub-module, `bilinear_coord_step`. It is reused for the y axis, advancing once per line.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-LINE → every output reads 0 within the same cycle; state returns to IDLE.
2. **Full default frame:** `src_row_done` every 700 cycles, `dp_ready`=1.
   - 768 lines × 1024 `pix_valid`.
   - Pixel 0 (x_int, x_frac) = (0, 0x0000); pixel 1 = (0, 0xA000); pixel 2 = (1, 0x4000).
   - 479 `src_row_release` pulses; one `frame_done`.
3. **Row gating:** after one `src_row_done`, no `pix_valid`; line 0 starts 2 cycles after the second pulse. Destination line 2 shows `y_int`=1, `y_frac`=0x4000 and waits for row 3.
4. **Backpressure:** drop `dp_ready` for 3 cycles at pixel 500 → outputs frozen; line still delivers exactly 1024 pixels in order.
5. **Boundaries:**
   - Pixel 1023: `x_int`=639, `x_frac`=0x6000, `x_last`=1.
   - Line 767: `y_int`=479, `y_frac`=0x6000, `y_last`=1.
   - Line 767 needs only 480 rows written.
   - Extra `src_row_done` pulses saturate `rows_wr` at 480.
6. **Overrun:** `frame_start` during LINE → one-cycle `frame_overrun`; the frame completes with the full 768×1024 output.
